fp_half_accumulator: RTL and testbench
======================================

# fp_half_accumulator

Sequential FP16 (1/5/10, bias 15) accumulator directly downstream of the half-precision multiplier in the MDP value datapath. It takes products one at a time over a four-phase valid/ack handshake and adds each into a running sum. On the term flagged last, it presents the sum to the next stage with a done/ack handshake. Arithmetic matches the multiplier: truncation rounding, no subnormals, no NaN/Inf.

## Interface
- CNT_W, 8, width of the saturating term counter
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; 0 forces the reset state immediately
- clear  input  1  synchronous; zeroes accumulator and counter, honoured only in IDLE
- in_data  input  16  FP16 term (multiplier output_z)
- in_valid  input  1  term available (multiplier done)
- in_last  input  1  term closes the current sum; sampled with in_data
- in_ack  output  1  capture acknowledge (drives multiplier ack)
- sum_z  output  16  final FP16 sum, valid while done=1
- term_count  output  CNT_W  terms in the current sum, saturates at all-ones
- done  output  1  sum_z valid
- ack  input  1  downstream has taken sum_z

## Operation
- Reset values: in_ack=0, done=0, sum_z=0x0000, term_count=0, accumulator=+0, state=IDLE. Reset mid-operation aborts the current term; the term is lost.
- States: IDLE, ALIGN, ADD, NORM, PACK, OUT.
- IDLE:
  - clear=1: acc=+0, term_count=0; no capture that cycle (clear beats in_valid).
  - Else, if in_valid=1 and in_ack=0: capture in_data and in_last, set in_ack=1, go to ALIGN.
- in_ack is four-phase. It stays 1 until in_valid is sampled 0, independent of state. A new capture requires in_ack=0.
- Zero rule: an operand with exponent 0 is treated as +0 (mantissa ignored).
- ALIGN: unpack both operands with the hidden bit (11-bit mantissa). Order them by magnitude (exponent, then mantissa). Right-shift the smaller by the exponent difference in one cycle; a difference >=12 makes it zero. Result sign = sign of the larger.
- ADD:
  - Same signs: 12-bit sum.
  - Otherwise: larger minus smaller.
  - Carry at bit 11: shift right 1, exponent+1.
  - Result mantissa 0: go to PACK with +0.
- NORM: while bit 10 = 0, shift left 1 and decrement exponent, one bit per cycle (at most 10 cycles). If the exponent reaches 0, flush to +0.
- PACK:
  - Exponent >=31: saturate to sign|0x7BFF.
  - Write acc. Increment term_count (saturating).
  - Captured last=1: go to OUT. Otherwise go to IDLE.
- OUT: done=1, sum_z=acc.
  - Hold both until ack=1.
  - On ack: done=0, acc=+0, term_count=0, go to IDLE.
  - in_valid is not captured in OUT.
- Exact cancellation yields +0 (0x0000), never 0x8000.

## Timing
- Capture edge to PACK: 3 cycles when no left-normalization is needed, plus 1 cycle per left shift (worst case 13).
- done rises on the edge after PACK for last terms.
- Earliest next capture is the cycle after returning to IDLE, provided in_valid has dropped and in_ack is 0.
- ack is sampled only in OUT; ack held high across OUT entry completes in 1 cycle.
- sum_z holds its last value after ack until the next OUT.

## Test plan
- Reset, single term 0x3C00 with last=1 → done=1, sum_z=0x3C00, term_count=1; ack → done=0 next cycle.
- 0x3C00, then 0x4000 with last → sum_z=0x4200; 0x4000, then 0x3800 with last → 0x4100.
- Cancellation and alignment:
  - 0x3C00, then 0xBC00 with last → sum_z=0x0000.
  - 0x6000, then 0x0400 with last → 0x6000 (difference >=12).
  - 0x3E00, then 0xBC00 with last → 0x3800 (exercises NORM).
- 0x7BFF, then 0x7BFF with last → sum_z=0x7BFF (saturation); 0xFBFF, then 0xFBFF with last → 0xFBFF.
- Handshake:
  - Hold in_valid high 4 cycles after capture → in_ack stays 1, only one term counted.
  - Hold ack low 10 cycles in OUT with in_valid=1 → done and sum_z stable, no capture.
  - clear and in_valid in the same IDLE cycle → no capture, acc=0.
- Assert reset=0 during NORM of the second term → all outputs return to reset values immediately; a fresh 0x4200 with last → sum_z=0x4200, term_count=1.

Source files
------------

// File: rtl/fp_half_accumulator.sv
// ============================================================================
// fp_half_accumulator
// Sequential FP16 (1/5/10, bias 15) accumulator: sums handshaked terms with
// truncation, flush-to-zero and saturation; presents the sum on the last term.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fp_half_accumulator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [15:0]      in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ack,
    output logic [15:0]      sum_z,
    output logic [CNT_W-1:0] term_count,
    output logic             done,
    input  logic             ack
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_PACK  = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    state_t      r_state;
    logic [15:0] r_acc;
    logic [15:0] r_term;
    logic        r_last;
    logic        r_sign;
    logic        r_sub;
    logic [5:0]  r_exp;
    logic [10:0] r_mant_l;
    logic [10:0] r_mant_s;
    logic [10:0] r_mant;

    logic [4:0]       w_a_exp, w_b_exp, w_big_exp, w_small_exp, w_diff;
    logic [10:0]      w_a_mant, w_b_mant, w_big_mant, w_small_mant, w_shifted;
    logic             w_a_sign, w_b_sign, w_big_sign, w_small_sign, w_a_ge;
    logic [11:0]      w_sum;
    logic [15:0]      w_packed;
    logic [CNT_W-1:0] w_cnt_next;

    // Zero-exponent operands collapse to +0 regardless of sign or fraction.
    always_comb begin
        w_a_exp  = r_acc[14:10];
        w_b_exp  = r_term[14:10];
        w_a_mant = (w_a_exp == 5'd0) ? 11'd0 : {1'b1, r_acc[9:0]};
        w_b_mant = (w_b_exp == 5'd0) ? 11'd0 : {1'b1, r_term[9:0]};
        w_a_sign = (w_a_exp == 5'd0) ? 1'b0 : r_acc[15];
        w_b_sign = (w_b_exp == 5'd0) ? 1'b0 : r_term[15];
        w_a_ge   = {w_a_exp, w_a_mant} >= {w_b_exp, w_b_mant};

        w_big_exp    = w_a_ge ? w_a_exp  : w_b_exp;
        w_big_mant   = w_a_ge ? w_a_mant : w_b_mant;
        w_big_sign   = w_a_ge ? w_a_sign : w_b_sign;
        w_small_exp  = w_a_ge ? w_b_exp  : w_a_exp;
        w_small_mant = w_a_ge ? w_b_mant : w_a_mant;
        w_small_sign = w_a_ge ? w_b_sign : w_a_sign;
        w_diff       = w_big_exp - w_small_exp;
        w_shifted    = (w_diff >= 5'd12) ? 11'd0 : (w_small_mant >> w_diff);

        w_sum = r_sub ? ({1'b0, r_mant_l} - {1'b0, r_mant_s})
                      : ({1'b0, r_mant_l} + {1'b0, r_mant_s});

        if (r_exp >= 6'd31)
            w_packed = {r_sign, 15'h7BFF};
        else if (r_mant[10])
            w_packed = {r_sign, r_exp[4:0], r_mant[9:0]};
        else
            w_packed = 16'h0000;

        w_cnt_next = (&term_count) ? term_count
                                   : term_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_acc      <= 16'h0000;
            r_term     <= 16'h0000;
            r_last     <= 1'b0;
            r_sign     <= 1'b0;
            r_sub      <= 1'b0;
            r_exp      <= 6'd0;
            r_mant_l   <= 11'd0;
            r_mant_s   <= 11'd0;
            r_mant     <= 11'd0;
            in_ack     <= 1'b0;
            sum_z      <= 16'h0000;
            term_count <= '0;
            done       <= 1'b0;
        end else begin
            // Four-phase release runs regardless of the datapath state.
            if (in_ack && !in_valid)
                in_ack <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (clear) begin
                        r_acc      <= 16'h0000;
                        term_count <= '0;
                    end else if (in_valid && !in_ack) begin
                        r_term  <= in_data;
                        r_last  <= in_last;
                        in_ack  <= 1'b1;
                        r_state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    r_sign   <= w_big_sign;
                    r_sub    <= w_big_sign ^ w_small_sign;
                    r_exp    <= {1'b0, w_big_exp};
                    r_mant_l <= w_big_mant;
                    r_mant_s <= w_shifted;
                    r_state  <= S_ADD;
                end
                S_ADD: begin
                    if (w_sum == 12'd0) begin
                        r_mant  <= 11'd0;
                        r_exp   <= 6'd0;
                        r_sign  <= 1'b0;
                        r_state <= S_PACK;
                    end else if (w_sum[11]) begin
                        r_mant  <= w_sum[11:1];
                        r_exp   <= r_exp + 6'd1;
                        r_state <= S_NORM;
                    end else begin
                        r_mant  <= w_sum[10:0];
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (r_mant[10]) begin
                        r_state <= S_PACK;
                    end else if (r_exp <= 6'd1) begin
                        r_mant  <= 11'd0;
                        r_exp   <= 6'd0;
                        r_sign  <= 1'b0;
                        r_state <= S_PACK;
                    end else begin
                        r_mant <= {r_mant[9:0], 1'b0};
                        r_exp  <= r_exp - 6'd1;
                    end
                end
                S_PACK: begin
                    r_acc      <= w_packed;
                    term_count <= w_cnt_next;
                    if (r_last) begin
                        sum_z   <= w_packed;
                        done    <= 1'b1;
                        r_state <= S_OUT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_OUT: begin
                    if (ack) begin
                        done       <= 1'b0;
                        r_acc      <= 16'h0000;
                        term_count <= '0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_half_accumulator.sv
// ============================================================================
// tb_fp_half_accumulator
// Directed self-checking bench for fp_half_accumulator.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fp_half_accumulator;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ack;
    logic [15:0] sum_z;
    logic [7:0]  term_count;
    logic        done;
    logic        ack = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    fp_half_accumulator #(.CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ack     (in_ack),
        .sum_z      (sum_z),
        .term_count (term_count),
        .done       (done),
        .ack        (ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic last);
        int k;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        k = 0;
        while (!in_ack && k < 40) begin tick(); k++; end
        if (!in_ack) check("capture_timeout", {31'd0, in_ack}, 32'd1);
        in_valid = 1'b0;
        k = 0;
        while (in_ack && k < 40) begin tick(); k++; end
        if (in_ack) check("release_timeout", {31'd0, in_ack}, 32'd0);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 40) begin tick(); k++; end
        if (!done) check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("done_after_ack", {31'd0, done}, 32'd0);
    endtask

    task automatic pair(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_sum);
        send(a, 1'b0);
        send(b, 1'b1);
        wait_done();
        check(tag, {16'd0, sum_z}, {16'd0, exp_sum});
        check({tag, "_cnt"}, {24'd0, term_count}, 32'd2);
        do_ack();
    endtask

    initial begin
        reset = 1'b0;
        #12;
        check("rst_in_ack", {31'd0, in_ack}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {16'd0, sum_z}, 32'h0);
        check("rst_cnt", {24'd0, term_count}, 32'd0);
        reset = 1'b1;
        tick();

        // single term
        send(16'h3C00, 1'b1);
        wait_done();
        check("single_sum", {16'd0, sum_z}, 32'h3C00);
        check("single_cnt", {24'd0, term_count}, 32'd1);
        do_ack();

        pair("add_1_2", 16'h3C00, 16'h4000, 16'h4200);
        pair("add_2_half", 16'h4000, 16'h3800, 16'h4100);
        pair("cancel", 16'h3C00, 16'hBC00, 16'h0000);
        pair("far_align", 16'h6000, 16'h0400, 16'h6000);
        pair("norm", 16'h3E00, 16'hBC00, 16'h3800);
        pair("sat_pos", 16'h7BFF, 16'h7BFF, 16'h7BFF);
        pair("sat_neg", 16'hFBFF, 16'hFBFF, 16'hFBFF);

        // in_valid held high after capture: ack stays up, term counted once
        in_data = 16'h3C00; in_last = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 40 && !in_ack; k++) tick();
        for (int k = 0; k < 4; k++) tick();
        check("hold_in_ack", {31'd0, in_ack}, 32'd1);
        in_valid = 1'b0;
        tick();
        send(16'h3C00, 1'b1);
        wait_done();
        check("hold_sum", {16'd0, sum_z}, 32'h4000);
        check("hold_cnt", {24'd0, term_count}, 32'd2);
        do_ack();

        // ack withheld in OUT with a pending term
        send(16'h4000, 1'b1);
        wait_done();
        in_data = 16'h3C00; in_last = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("out_done", {31'd0, done}, 32'd1);
            check("out_sum", {16'd0, sum_z}, 32'h4000);
            check("out_no_cap", {31'd0, in_ack}, 32'd0);
        end
        in_valid = 1'b0;
        do_ack();
        check("out_cnt_clr", {24'd0, term_count}, 32'd0);
        check("out_sum_hold", {16'd0, sum_z}, 32'h4000);

        // clear beats in_valid in IDLE
        send(16'h3C00, 1'b0);
        for (int k = 0; k < 6; k++) tick();
        clear = 1'b1; in_data = 16'h4000; in_last = 1'b0; in_valid = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        tick();
        check("clr_no_cap", {31'd0, in_ack}, 32'd0);
        check("clr_cnt", {24'd0, term_count}, 32'd0);
        send(16'h3800, 1'b1);
        wait_done();
        check("clr_sum", {16'd0, sum_z}, 32'h3800);
        check("clr_sum_cnt", {24'd0, term_count}, 32'd1);
        do_ack();

        // reset during NORM of the second term
        send(16'h3E00, 1'b0);
        for (int k = 0; k < 6; k++) tick();
        in_data = 16'hBC00; in_last = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 40 && !in_ack; k++) tick();
        tick();
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        check("arst_in_ack", {31'd0, in_ack}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_sum", {16'd0, sum_z}, 32'h0);
        check("arst_cnt", {24'd0, term_count}, 32'd0);
        #3;
        reset = 1'b1;
        tick();
        send(16'h4200, 1'b1);
        wait_done();
        check("post_rst_sum", {16'd0, sum_z}, 32'h4200);
        check("post_rst_cnt", {24'd0, term_count}, 32'd1);
        do_ack();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
